// File: rtl/rfile_dmach.sv
// General-purpose register file (2R/1W) with NCH DMA channel descriptors.
// Each channel holds an address and a count, and a step strobe advances the address and decrements the count.
module rfile_dmach #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_N   = 16,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NCH     = 2,
  parameter int unsigned STRIDE  = 4,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-1:0]     i_a1,
  input  logic [REG_AW-1:0]     i_a2,
  output logic [DATA_W-1:0]     o_rd1,
  output logic [DATA_W-1:0]     o_rd2,
  input  logic [REG_AW-1:0]     i_a3,
  input  logic [DATA_W-1:0]     i_wd3,
  input  logic                  i_we3,
  input  logic [NCH-1:0]        i_ch_we_sa,
  input  logic [NCH-1:0]        i_ch_we_dnum,
  input  logic [NCH*DATA_W-1:0] i_ch_sa_in,
  input  logic [NCH*DATA_W-1:0] i_ch_dnum_in,
  input  logic [NCH-1:0]        i_ch_step,
  output logic [NCH*DATA_W-1:0] o_ch_sa,
  output logic [NCH*DATA_W-1:0] o_ch_dnum,
  output logic [NCH-1:0]        o_ch_busy,
  output logic [NCH-1:0]        o_ch_done
);

  logic [DATA_W-1:0]           regs_q [REG_N];
  logic [NCH-1:0][DATA_W-1:0]  sa_q;
  logic [NCH-1:0][DATA_W-1:0]  dnum_q;
  logic [NCH-1:0]              done_q;
  logic                        wr_ok;

  assign wr_ok = i_we3 && !(ZERO_R0 && (i_a3 == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[i_a3] <= i_wd3;
    end
  end

  // Forwarding uses wr_ok, so a discarded r0 write is never forwarded.
  always_comb begin
    o_rd1 = regs_q[i_a1];
    o_rd2 = regs_q[i_a2];
    if (BYPASS && wr_ok && (i_a1 == i_a3)) o_rd1 = i_wd3;
    if (BYPASS && wr_ok && (i_a2 == i_a3)) o_rd2 = i_wd3;
    if (ZERO_R0 && (i_a1 == '0)) o_rd1 = '0;
    if (ZERO_R0 && (i_a2 == '0)) o_rd2 = '0;
  end

  // A load on either field suppresses the step for both fields in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q   <= '0;
      dnum_q <= '0;
      done_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        done_q[k] <= 1'b0;
        if (i_ch_we_sa[k] || i_ch_we_dnum[k]) begin
          if (i_ch_we_sa[k])   sa_q[k]   <= i_ch_sa_in[k*DATA_W +: DATA_W];
          if (i_ch_we_dnum[k]) dnum_q[k] <= i_ch_dnum_in[k*DATA_W +: DATA_W];
        end else if (i_ch_step[k] && (dnum_q[k] != '0)) begin
          sa_q[k]   <= sa_q[k] + DATA_W'(STRIDE);
          dnum_q[k] <= dnum_q[k] - DATA_W'(1);
          done_q[k] <= (dnum_q[k] == DATA_W'(1));
        end
      end
    end
  end

  always_comb begin
    o_ch_busy = '0;
    for (int unsigned k = 0; k < NCH; k++) o_ch_busy[k] = (dnum_q[k] != '0);
  end

  assign o_ch_sa   = sa_q;
  assign o_ch_dnum = dnum_q;
  assign o_ch_done = done_q;

endmodule

// File: tb/tb_rfile_dmach.sv
// Scoreboard bench for rfile_dmach: one instance with forwarding enabled and one without, sharing the same inputs.
module tb_rfile_dmach;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we3;
  logic [1:0]  we_sa, we_dnum, step;
  logic [63:0] sa_in, dnum_in;

  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic [63:0] ch_sa, ch_dnum, ch_sa_nb, ch_dnum_nb;
  logic [1:0]  busy, done, busy_nb, done_nb;

  rfile_dmach #(.DATA_W(32), .REG_N(16), .REG_AW(4), .NCH(2), .STRIDE(4),
                .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_a1(a1), .i_a2(a2), .o_rd1(rd1), .o_rd2(rd2),
    .i_a3(a3), .i_wd3(wd3), .i_we3(we3), .i_ch_we_sa(we_sa), .i_ch_we_dnum(we_dnum),
    .i_ch_sa_in(sa_in), .i_ch_dnum_in(dnum_in), .i_ch_step(step),
    .o_ch_sa(ch_sa), .o_ch_dnum(ch_dnum), .o_ch_busy(busy), .o_ch_done(done));

  rfile_dmach #(.DATA_W(32), .REG_N(16), .REG_AW(4), .NCH(2), .STRIDE(4),
                .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .i_a1(a1), .i_a2(a2), .o_rd1(rd1_nb), .o_rd2(rd2_nb),
    .i_a3(a3), .i_wd3(wd3), .i_we3(we3), .i_ch_we_sa(we_sa), .i_ch_we_dnum(we_dnum),
    .i_ch_sa_in(sa_in), .i_ch_dnum_in(dnum_in), .i_ch_step(step),
    .o_ch_sa(ch_sa_nb), .o_ch_dnum(ch_dnum_nb), .o_ch_busy(busy_nb), .o_ch_done(done_nb));

  always #5 clk = ~clk;

  // Output selectors
  localparam int RD1 = 0, RD2 = 1, SA0 = 2, DN0 = 3, BSY0 = 4, DONE0 = 5,
                 SA1 = 6, DN1 = 7, BSY1 = 8, DONE1 = 9, RD1NB = 10, RD2NB = 11;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(int sel);
    case (sel)
      RD1:   return rd1;
      RD2:   return rd2;
      SA0:   return ch_sa[31:0];
      DN0:   return ch_dnum[31:0];
      BSY0:  return {31'd0, busy[0]};
      DONE0: return {31'd0, done[0]};
      SA1:   return ch_sa[63:32];
      DN1:   return ch_dnum[63:32];
      BSY1:  return {31'd0, busy[1]};
      DONE1: return {31'd0, done[1]};
      RD1NB: return rd1_nb;
      RD2NB: return rd2_nb;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: compares each expectation against the DUT in the cycle it was issued for.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sbq.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)", e.name, e.cyc, cyc);
      end else begin
        a = act(e.sel);
        if (a !== e.exp) begin
          bad++;
          $display("FAIL %s: cycle %0d actual=%h expected=%h", e.name, cyc, a, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ch(input int ch, input logic [31:0] sa, input logic [31:0] dn,
                           input logic b, input logic d, input string tag);
    int o;
    o = (ch == 0) ? SA0 : SA1;
    expect_v(o,     sa,          {tag, "_sa"});
    expect_v(o + 1, dn,          {tag, "_dnum"});
    expect_v(o + 2, {31'd0, b},  {tag, "_busy"});
    expect_v(o + 3, {31'd0, d},  {tag, "_done"});
  endtask

  initial begin
    rst_n = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; we3 = 1'b0;
    we_sa = '0; we_dnum = '0; step = '0; sa_in = '0; dnum_in = '0;
    next(); next();
    rst_n = 1'b1;

    // Reset state: every register and both channels read zero.
    expect_ch(0, 32'h0, 32'h0, 1'b0, 1'b0, "rst_ch0");
    expect_ch(1, 32'h0, 32'h0, 1'b0, 1'b0, "rst_ch1");
    for (int i = 0; i < 16; i++) begin
      a1 = 4'(i); a2 = 4'(15 - i);
      expect_v(RD1, 32'h0, "rst_rd1");
      expect_v(RD2, 32'h0, "rst_rd2");
      next();
    end

    // Plain write then read.
    we3 = 1'b1; a3 = 4'd5; wd3 = 32'hDEADBEEF; a1 = 4'd0; a2 = 4'd0;
    next();
    we3 = 1'b0; a1 = 4'd5;
    expect_v(RD1,   32'hDEADBEEF, "wr_r5");
    expect_v(RD1NB, 32'hDEADBEEF, "wr_r5_nb");

    // r0 is hardwired to zero and never forwarded.
    next();
    we3 = 1'b1; a3 = 4'd0; wd3 = 32'h1234; a1 = 4'd0;
    expect_v(RD1,   32'h0, "r0_same");
    expect_v(RD1NB, 32'h0, "r0_same_nb");
    next();
    we3 = 1'b0;
    expect_v(RD1,   32'h0, "r0_next");
    next();
    expect_v(RD1NB, 32'h0, "r0_later_nb");

    // Forwarding vs no forwarding on r3.
    next();
    we3 = 1'b1; a3 = 4'd3; wd3 = 32'hA5A5A5A5; a2 = 4'd3;
    expect_v(RD2,   32'hA5A5A5A5, "fwd_same");
    expect_v(RD2NB, 32'h0,        "nofwd_same");
    next();
    we3 = 1'b0;
    expect_v(RD2,   32'hA5A5A5A5, "fwd_next");
    expect_v(RD2NB, 32'hA5A5A5A5, "nofwd_next");

    // Channel 0: load 0x100/3, three back-to-back steps, then an extra step.
    next();
    we_sa = 2'b01; we_dnum = 2'b01; sa_in[31:0] = 32'h100; dnum_in[31:0] = 32'd3;
    next();
    we_sa = '0; we_dnum = '0; step = 2'b01;
    expect_ch(0, 32'h100, 32'd3, 1'b1, 1'b0, "c0_load");
    next();
    expect_ch(0, 32'h104, 32'd2, 1'b1, 1'b0, "c0_s1");
    next();
    expect_ch(0, 32'h108, 32'd1, 1'b1, 1'b0, "c0_s2");
    next();
    step = '0;
    expect_ch(0, 32'h10C, 32'd0, 1'b0, 1'b1, "c0_s3");
    next();
    step = 2'b01;
    expect_ch(0, 32'h10C, 32'd0, 1'b0, 1'b0, "c0_after");
    next();
    step = '0;
    expect_ch(0, 32'h10C, 32'd0, 1'b0, 1'b0, "c0_s4");

    // Channel 1: address wrap, then load-over-step conflict.
    next();
    we_sa = 2'b10; we_dnum = 2'b10; sa_in[63:32] = 32'hFFFFFFFC; dnum_in[63:32] = 32'd2;
    next();
    we_sa = '0; we_dnum = '0; step = 2'b10;
    expect_ch(1, 32'hFFFFFFFC, 32'd2, 1'b1, 1'b0, "c1_load");
    next();
    we_dnum = 2'b10; dnum_in[63:32] = 32'd5;
    expect_ch(1, 32'h0, 32'd1, 1'b1, 1'b0, "c1_wrap");
    expect_ch(0, 32'h10C, 32'd0, 1'b0, 1'b0, "c0_indep");
    next();
    we_dnum = '0; step = 2'b10;
    expect_ch(1, 32'h0, 32'd5, 1'b1, 1'b0, "c1_conflict");

    // Reset mid-transfer while stepping; count must not pass through 1->0.
    next();
    expect_ch(1, 32'h4, 32'd4, 1'b1, 1'b0, "c1_step");
    rst_n = 1'b0;
    next();
    rst_n = 1'b1; a2 = 4'd3;
    expect_ch(1, 32'h0, 32'd0, 1'b0, 1'b0, "mid_rst");
    expect_v(RD2, 32'h0, "mid_rst_r3");
    next();
    step = '0;
    expect_ch(1, 32'h0, 32'd0, 1'b0, 1'b0, "post_rst");
    next(); next();

    // Every queued expectation must have been consumed by the monitor.
    for (int i = 0; i < 10 && sbq.size() > 0; i++) next();
    if (sbq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    stim_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL watchdog: stimulus did not complete, required completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
